// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM with ready handshakes, wait timeout and perf counters
// Ports: CLK/RST (sync, active-high); op/func/zero from IR and ALU; imem_ready/dmem_ready handshakes;
//        datapath strobes and selects (PCWre, IRWre, RegWre, PCSrc, RegDst, WrRegDSrc, DBDataSrc,
//        ALUSrcB, ExtSel, ALUOp), memory requests, halted/fault status, instr_cnt/cycle_cnt counters.
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 8,
  parameter int TO_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             PCWre,
  output logic             IRWre,
  output logic             RegWre,
  output logic [1:0]       PCSrc,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             DBDataSrc,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [3:0]       ALUOp,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT, S_FAULT} state_t;
  localparam logic [TO_W-1:0] TO = TO_W'(TIMEOUT);
  state_t state, nxt;
  logic [TO_W-1:0] wcnt;
  logic rtype, is_jr, valid_r, is_addi, is_lw, is_sw, is_beq, is_j, is_jal, is_halt, legal, imm_op, alu_hold;
  logic [3:0] alu_op;
  assign rtype   = op == 6'b000000;
  assign is_jr   = rtype && func == 6'b001000;
  assign valid_r = rtype && (func == 6'b100000 || func == 6'b100010 || func == 6'b100100 ||
                             func == 6'b100101 || func == 6'b101010 || func == 6'b001000);
  assign is_addi = op == 6'b001000;
  assign is_lw   = op == 6'b100011;
  assign is_sw   = op == 6'b101011;
  assign is_beq  = op == 6'b000100;
  assign is_j    = op == 6'b000010;
  assign is_jal  = op == 6'b000011;
  assign is_halt = op == 6'b111111;
  assign legal   = valid_r | is_addi | is_lw | is_sw | is_beq | is_j | is_jal | is_halt;
  assign imm_op  = is_addi | is_lw | is_sw;
  assign alu_op  = is_beq ? 4'b0001 :
                   !rtype ? 4'b0000 :
                   func == 6'b100010 ? 4'b0001 :
                   func == 6'b100100 ? 4'b0100 :
                   func == 6'b100101 ? 4'b0101 :
                   func == 6'b101010 ? 4'b0110 : 4'b0000;
  assign alu_hold = state == S_EXE || state == S_MEM || state == S_WB;
  always_ff @(posedge CLK)
    state <= RST ? S_IF : nxt;
  // ready beats the timeout because the ready check comes first in each wait state
  always_comb begin
    nxt = state;
    case (state)
      S_IF:    nxt = imem_ready ? S_ID : (wcnt == TO ? S_FAULT : S_IF);
      S_ID:    nxt = !legal ? S_FAULT : is_halt ? S_HALT : (is_j | is_jal | is_jr) ? S_IF : S_EXE;
      S_EXE:   nxt = is_beq ? S_IF : (is_lw | is_sw) ? S_MEM : S_WB;
      S_MEM:   nxt = dmem_ready ? (is_sw ? S_IF : S_WB) : (wcnt == TO ? S_FAULT : S_MEM);
      S_WB:    nxt = S_IF;
      default: nxt = state;
    endcase
  end
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    PCSrc     = 2'b00;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    ALUSrcB   = alu_hold && imm_op;
    ExtSel    = alu_hold && imm_op;
    ALUOp     = alu_hold ? alu_op : 4'b0000;
    halted    = state == S_HALT;
    fault     = state == S_FAULT;
    case (state)
      S_IF: begin
        imem_req = 1'b1;
        IRWre    = imem_ready;
      end
      S_ID: begin
        PCWre  = is_j | is_jal | is_jr;
        PCSrc  = is_jr ? 2'b11 : (is_j | is_jal) ? 2'b10 : 2'b00;
        RegWre = is_jal;
      end
      S_EXE: begin
        PCWre = is_beq;
        PCSrc = (is_beq && zero) ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        PCWre    = is_sw && dmem_ready;
      end
      S_WB: begin
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
        RegDst    = rtype ? 2'b10 : 2'b01;
        DBDataSrc = is_lw;
      end
      default: ;
    endcase
  end
  // counts consecutive not-ready cycles within one IF or MEM visit
  always_ff @(posedge CLK)
    wcnt <= (RST || nxt != state) ? '0 :
            ((state == S_IF && !imem_ready) || (state == S_MEM && !dmem_ready)) ? wcnt + TO_W'(1) : wcnt;
  // halt retires without a PC load, so its entry is counted explicitly
  always_ff @(posedge CLK)
    if (RST) begin
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (state != S_HALT && state != S_FAULT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (PCWre || (state == S_ID && nxt == S_HALT)) instr_cnt <= instr_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: self-checking bench for mc_ctrl_fsm against an instruction-level timing model
module tb_mc_ctrl_fsm;
  logic CLK = 0, RST = 1;
  logic [5:0] op = 0, func = 0;
  logic zero = 0, imem_ready = 0, dmem_ready = 0;
  logic imem_req, dmem_req, dmem_we, PCWre, IRWre, RegWre, WrRegDSrc, DBDataSrc, ALUSrcB, ExtSel, halted, fault;
  logic [1:0] PCSrc, RegDst;
  logic [3:0] ALUOp;
  logic [31:0] instr_cnt, cycle_cnt;
  int errors = 0, checks = 0;
  int m_instr = 0, m_cyc = 0;

  mc_ctrl_fsm #(.TIMEOUT(8), .TO_W(4), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .op(op), .func(func), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .PCSrc(PCSrc), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .ALUOp(ALUOp), .halted(halted), .fault(fault), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset;
    RST = 1; imem_ready = 0; dmem_ready = 0;
    @(negedge CLK); @(negedge CLK);
    RST = 0; m_instr = 0; m_cyc = 0;
  endtask

  // Drives one instruction with iw fetch waits and dw data waits, then checks it against the
  // latency/strobe rules derived from the instruction class.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int iw, input int dw, input logic z, input string nm);
    int ifp, mp, irw, rw, pcw, base, L, erw;
    logic [1:0] pcs, rd, epcs, erd;
    logic wds, dbs, asb, we, r, isj, isjal, isjr, isbeq, islw, issw, isaddi, easb;
    logic [3:0] aop, eaop;
    ifp = 0; mp = 0; irw = 0; rw = 0; pcw = 0; pcs = 0; rd = 0; wds = 0; dbs = 0; asb = 0; we = 0; aop = 0;
    r = o == 6'h00; isj = o == 6'h02; isjal = o == 6'h03; isjr = r && f == 6'h08;
    isbeq = o == 6'h04; islw = o == 6'h23; issw = o == 6'h2b; isaddi = o == 6'h08;
    base = (isj || isjal || isjr) ? 2 : isbeq ? 3 : islw ? 5 : 4;
    L = base + iw + ((islw || issw) ? dw : 0);
    epcs = isjr ? 2'b11 : (isj || isjal) ? 2'b10 : (isbeq && z) ? 2'b01 : 2'b00;
    erw = (isj || isjr || isbeq || issw) ? 0 : 1;
    erd = isjal ? 2'b00 : r ? 2'b10 : 2'b01;
    easb = isaddi || islw || issw;
    if (isj || isjal || isjr) eaop = 4'b0000;
    else if (isbeq) eaop = 4'b0001;
    else if (r) eaop = f == 6'h22 ? 4'b0001 : f == 6'h24 ? 4'b0100 : f == 6'h25 ? 4'b0101 : f == 6'h2a ? 4'b0110 : 4'b0000;
    else eaop = 4'b0000;
    op = o; func = f; zero = z;
    for (int c = 1; c <= 40 && pcw == 0 && !halted && !fault; c++) begin
      imem_ready = ifp >= iw;
      dmem_ready = mp >= dw;
      #1;
      if (imem_req) ifp++;
      if (dmem_req) begin mp++; we = dmem_we; end
      if (IRWre) irw = c;
      if (RegWre) begin rw++; rd = RegDst; wds = WrRegDSrc; dbs = DBDataSrc; end
      if (PCWre) begin pcw = c; pcs = PCSrc; aop = ALUOp; asb = ALUSrcB; end
      @(negedge CLK);
    end
    m_instr++; m_cyc += L;
    checks++; if (pcw !== L) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, pcw, L); end
    checks++; if (irw !== iw + 1) begin errors++; $display("FAIL %s irwre_cycle got %0d want %0d", nm, irw, iw + 1); end
    checks++; if (pcs !== epcs) begin errors++; $display("FAIL %s pcsrc got %b want %b", nm, pcs, epcs); end
    checks++; if (rw !== erw) begin errors++; $display("FAIL %s regwre_pulses got %0d want %0d", nm, rw, erw); end
    if (erw == 1) begin
      checks++; if ({rd, wds, dbs} !== {erd, !isjal, islw}) begin errors++;
        $display("FAIL %s wb_sel got %b want %b", nm, {rd, wds, dbs}, {erd, !isjal, islw}); end
    end
    checks++; if (mp !== ((islw || issw) ? dw + 1 : 0) || we !== issw) begin errors++;
      $display("FAIL %s dmem got req=%0d we=%b want req=%0d we=%b", nm, mp, we, (islw || issw) ? dw + 1 : 0, issw); end
    checks++; if ({aop, asb} !== {eaop, easb}) begin errors++; $display("FAIL %s alu got %b want %b", nm, {aop, asb}, {eaop, easb}); end
    checks++; if (instr_cnt !== 32'(m_instr) || cycle_cnt !== 32'(m_cyc)) begin errors++;
      $display("FAIL %s counters got %0d/%0d want %0d/%0d", nm, instr_cnt, cycle_cnt, m_instr, m_cyc); end
    checks++; if (fault !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL %s status got f=%b h=%b want 0 0", nm, fault, halted); end
  endtask

  task automatic test_reset;
    op = 6'h08; func = 0;
    do_reset;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_imem_req got %b want 1", imem_req); end
    checks++; if ({dmem_req, dmem_we, PCWre, IRWre, RegWre, PCSrc, RegDst, WrRegDSrc, DBDataSrc, ALUSrcB, ExtSel, ALUOp, halted, fault} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {dmem_req, dmem_we, PCWre, IRWre, RegWre, PCSrc, RegDst, WrRegDSrc, DBDataSrc, ALUSrcB, ExtSel, ALUOp, halted, fault}); end
    checks++; if (instr_cnt !== 0 || cycle_cnt !== 0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", instr_cnt, cycle_cnt); end
    imem_ready = 1; #1;
    checks++; if (IRWre !== 1'b1) begin errors++; $display("FAIL reset_irwre got %b want 1", IRWre); end
    @(negedge CLK);
    do_reset;
  endtask

  task automatic test_directed;
    run_instr(6'h08, 6'h00, 0, 0, 0, "addi");
    run_instr(6'h23, 6'h00, 0, 3, 0, "lw_wait3");
    run_instr(6'h04, 6'h00, 0, 0, 1, "beq_taken");
    run_instr(6'h04, 6'h00, 0, 0, 0, "beq_not_taken");
    run_instr(6'h03, 6'h00, 0, 0, 0, "jal");
    run_instr(6'h00, 6'h08, 0, 0, 0, "jr");
    run_instr(6'h08, 6'h00, 8, 0, 0, "addi_iwait8");
    run_instr(6'h2b, 6'h00, 2, 8, 0, "sw_dwait8");
  endtask

  task automatic test_random;
    logic [11:0] tbl [12];
    tbl = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h2a}, {6'h00, 6'h08},
            {6'h08, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00}, {6'h04, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}};
    for (int i = 0; i < 40; i++) begin
      logic [11:0] e;
      e = tbl[$urandom_range(11)];
      run_instr(e[11:6], e[5:0], $urandom_range(8), $urandom_range(8), 1'($urandom_range(1)), "random");
    end
  endtask

  task automatic test_halt;
    do_reset;
    op = 6'h3f; func = 0; imem_ready = 1;
    @(negedge CLK); @(negedge CLK);
    checks++; if (halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL halt_state got h=%b f=%b want 1 0", halted, fault); end
    checks++; if (instr_cnt !== 1 || cycle_cnt !== 2) begin errors++; $display("FAIL halt_counters got %0d/%0d want 1/2", instr_cnt, cycle_cnt); end
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (halted !== 1'b1 || instr_cnt !== 1 || cycle_cnt !== 2 || {imem_req, PCWre, IRWre, RegWre} !== 4'b0) begin errors++;
      $display("FAIL halt_sticky got h=%b cnt=%0d/%0d strobes=%b want 1 1/2 0000", halted, instr_cnt, cycle_cnt, {imem_req, PCWre, IRWre, RegWre}); end
  endtask

  task automatic test_timeout;
    do_reset;
    op = 6'h08; imem_ready = 0;
    repeat (8) @(negedge CLK);
    checks++; if (fault !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL if_timeout_early got f=%b req=%b want 0 1", fault, imem_req); end
    @(negedge CLK);
    checks++; if (fault !== 1'b1 || cycle_cnt !== 9) begin errors++; $display("FAIL if_timeout got f=%b cyc=%0d want 1 9", fault, cycle_cnt); end
    repeat (3) @(negedge CLK);
    checks++; if (cycle_cnt !== 9 || imem_req !== 1'b0 || fault !== 1'b1) begin errors++;
      $display("FAIL fault_sticky got cyc=%0d req=%b f=%b want 9 0 1", cycle_cnt, imem_req, fault); end
    do_reset;
    op = 6'h23; imem_ready = 1; dmem_ready = 0;
    repeat (11) @(negedge CLK);
    checks++; if (fault !== 1'b0 || dmem_req !== 1'b1) begin errors++; $display("FAIL mem_timeout_early got f=%b req=%b want 0 1", fault, dmem_req); end
    @(negedge CLK);
    checks++; if (fault !== 1'b1 || cycle_cnt !== 12) begin errors++; $display("FAIL mem_timeout got f=%b cyc=%0d want 1 12", fault, cycle_cnt); end
  endtask

  task automatic test_illegal;
    do_reset;
    op = 6'b111110; imem_ready = 1;
    @(negedge CLK); @(negedge CLK);
    checks++; if (fault !== 1'b1 || cycle_cnt !== 2 || instr_cnt !== 0) begin errors++;
      $display("FAIL bad_op got f=%b cnt=%0d/%0d want 1 0/2", fault, instr_cnt, cycle_cnt); end
    do_reset;
    op = 6'h00; func = 6'b000001; imem_ready = 1;
    @(negedge CLK); @(negedge CLK);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL bad_func got f=%b want 1", fault); end
  endtask

  task automatic test_rst_mid_mem;
    do_reset;
    op = 6'h2b; func = 0; imem_ready = 1; dmem_ready = 0;
    repeat (4) @(negedge CLK);
    #1;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL mid_mem_req got %b%b want 11", dmem_req, dmem_we); end
    RST = 1;
    @(negedge CLK);
    RST = 0; #1;
    checks++; if (imem_req !== 1'b1 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || instr_cnt !== 0 || cycle_cnt !== 0) begin errors++;
      $display("FAIL rst_mid_mem got ireq=%b dreq=%b we=%b cnt=%0d/%0d want 1 0 0 0/0", imem_req, dmem_req, dmem_we, instr_cnt, cycle_cnt); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_halt;
    test_timeout;
    test_illegal;
    test_rst_mid_mem;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control unit for the MIPS core, replacing the fixed-latency controller. It sequences IF → ID → EXE → MEM → WB and drives the existing datapath strobes. It adds three things the old controller lacks: variable-latency instruction and data memories through ready handshakes, a parametrised wait-timeout fault, and retire and cycle counters. It sits between the IR/instruction splitter (op, func) and the PC, register file, ALU and data memory enables.

## Interface
- TIMEOUT, default 8: maximum wait cycles allowed in IF or MEM without a ready; range 1..2^TO_W-1.
- TO_W, default 4: width of the wait counter.
- CNT_W, default 32: width of the performance counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- op  in  6  opcode from the IR.
- func  in  6  function field from the IR.
- zero  in  1  ALU zero flag, valid in EXE.
- imem_ready  in  1  instruction fetch completes this cycle.
- dmem_ready  in  1  data access completes this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write; 1 = store.
- PCWre  out  1  PC load strobe.
- IRWre  out  1  IR load strobe.
- RegWre  out  1  register file write.
- PCSrc  out  2  next-PC select: 00 = PC+4, 01 = branch, 10 = jump, 11 = rs.
- RegDst  out  2  write-register select: 00 = $31, 01 = rt, 10 = rd.
- WrRegDSrc  out  1  write-data select: 0 = PC+4, 1 = DB.
- DBDataSrc  out  1  DB source: 0 = ALU, 1 = memory.
- ALUSrcB  out  1  ALU B input: 1 = extended immediate.
- ExtSel  out  1  immediate extension: 1 = sign-extend.
- ALUOp  out  4  ALU operation: 0000 add, 0001 sub, 0100 and, 0101 or, 0110 slt.
- halted  out  1  state is HALT.
- fault  out  1  state is FAULT.
- instr_cnt  out  CNT_W  retired instructions.
- cycle_cnt  out  CNT_W  active cycles.

## Operation
- Supported instructions:
  - R-type (op 000000) with func 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 001000 jr.
  - addi 001000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011, halt 111111.
  - Any other op, or an unlisted func, goes to FAULT from ID.
- States: IF, ID, EXE, MEM, WB, HALT, FAULT. Outputs are combinational from the state, op, func and the ready inputs. Any output not listed for a state is 0.
- IF:
  - imem_req = 1.
  - On imem_ready: IRWre = 1, go to ID.
- ID:
  - j: PCWre = 1, PCSrc = 10, go to IF.
  - jal: additionally RegWre = 1, RegDst = 00, WrRegDSrc = 0.
  - jr: PCWre = 1, PCSrc = 11, go to IF.
  - halt: go to HALT (no PCWre).
  - Otherwise go to EXE.
- EXE:
  - ALUSrcB = 1 and ExtSel = 1 for addi, lw and sw.
  - ALUOp is 0000 for addi, lw and sw; 0001 for beq; R-type follows the func map.
  - beq: PCWre = 1, PCSrc = zero ? 01 : 00, go to IF.
  - lw and sw go to MEM; R-type and addi go to WB.
  - ALU control signals are held through MEM and WB.
- MEM:
  - dmem_req = 1, dmem_we = (op == sw).
  - On dmem_ready, sw: PCWre = 1, PCSrc = 00, go to IF.
  - On dmem_ready, lw: go to WB.
- WB:
  - RegWre = 1, WrRegDSrc = 1, PCWre = 1, PCSrc = 00.
  - RegDst = 10 for R-type, 01 otherwise.
  - DBDataSrc = 1 for lw.
  - Go to IF.
- Wait counter:
  - Cleared on every state change.
  - Increments on each IF or MEM cycle with ready low.
  - If the counter equals TIMEOUT while ready is still low, go to FAULT.
  - The ready input wins over the timeout in the same cycle.
- HALT and FAULT are sticky; only RST exits them. All strobes are 0 in both states.
- instr_cnt increments on every cycle where PCWre = 1, plus once on entry to HALT.
- cycle_cnt increments every cycle not in HALT or FAULT.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset:
  - RST high at an edge: next state is IF and both counters are 0.
  - RST has priority over every transition, including mid-MEM. An aborted store keeps dmem_req low from the next cycle.
  - Right after reset: imem_req = 1, every other output 0, halted = 0, fault = 0.
- Instruction latency in cycles with zero-wait memories (ready high on the first cycle):
  - j, jal, jr: 2.
  - beq: 3.
  - R-type, addi, sw: 4.
  - lw: 5.
- Each memory wait cycle adds 1 to the latency.
- Strobes (PCWre, IRWre, RegWre) are single-cycle pulses.

## Test plan
- Reset, then imem_ready stuck at 1 and an addi instruction → strobes IRWre@1, RegWre+PCWre@4 with RegDst = 01 and ALUSrcB = 1; instr_cnt = 1 after cycle 4.
- lw with dmem_ready low for 3 MEM cycles → WB reached at cycle 8 with DBDataSrc = 1; no fault.
- beq with zero = 1, then zero = 0 → PCSrc = 01, then PCSrc = 00, each with PCWre in cycle 3.
- imem_ready held at 0 with TIMEOUT = 8 → fault = 1 after the 9th IF cycle; cycle_cnt freezes at 9.
- jal → cycle 2 shows RegWre = 1, RegDst = 00, WrRegDSrc = 0, PCSrc = 10.
- Unknown op 111110 → FAULT; RST asserted during a MEM wait → next cycle in IF, counters = 0, dmem_req = 0.
